pe_periph_bus: RTL and testbench
================================

Name: pe_periph_bus

Overview:
- Parametrised CPU-side peripheral interconnect for the processing element.
- One-hot decodes core data accesses onto N memory-mapped slots (data RAM, RTC, PLIC, NI, future units).
- Per-slot read latency; stalls the core until read data returns.
- Read-return select is registered and tracked per accepted request; decode misses are captured as bus errors.

Parameters:
- N_SLOTS, 4, number of peripheral slots, 1..8; slot i owns region addr[31:24] == (1 << i).
- SLOT_LAT, 16'h0000, packed 2 bits per slot; slot i read latency = SLOT_LAT[2i+1:2i] + 1 cycles (1..4).
- ERR_RDATA, 32'h0000_0000, data returned on a read that hits no slot.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cpu_en_i  in  1  core memory operation enable.
- cpu_we_i  in  4  core byte write enables; 0 = read.
- cpu_addr_i  in  32  core address.
- cpu_rdata_o  out  32  read data to core.
- cpu_stall_o  out  1  holds the core while a multi-cycle read is pending.
- slv_en_o  out  N_SLOTS  one-hot slot enable.
- slv_rdata_i  in  32*N_SLOTS  packed slot read data; slot i is [32i+31:32i].
- err_o  out  1  sticky bus-error flag.
- err_addr_o  out  32  address of the first unserviced erroneous access.
- err_clr_i  in  1  one-cycle pulse that clears err_o.

Behaviour:
- Reset (asynchronous, active-low): FSM in IDLE, counter 0, all outputs 0.
- Decode is combinational. Slot i is hit when cpu_addr_i[31:24] == 8'(1 << i) and i < N_SLOTS. Any other value is a miss: zero bits, multiple bits, bit beyond N_SLOTS, or region 0x00.
- slv_en_o[i] = cpu_en_i && hit_i && (state == IDLE). No slot is enabled on a miss.
- Writes (cpu_we_i != 0) are posted:
  - One-cycle slot enable, no stall, FSM stays in IDLE.
  - A write miss raises err_o.
- Reads are accepted in IDLE. On accept:
  - The slot index is registered in sel_r.
  - The counter is loaded with L-1, where L is that slot's latency.
- FSM states:
  - IDLE: accept a read. L == 1 -> RESP next cycle; L > 1 -> WAIT.
  - WAIT: cpu_stall_o = 1. Decrement the counter each cycle; at 1 go to RESP. New cpu_en_i is ignored and no slot is enabled.
  - RESP: cpu_rdata_o = slv_rdata_i[sel_r] for exactly this cycle; cpu_stall_o = 0. A new access may be accepted this same cycle (RESP behaves as IDLE for acceptance).
- A miss read completes like latency 1: ERR_RDATA is driven in the following cycle, and err_o is raised.
- When no response is active, cpu_rdata_o holds the data-RAM slot (slot 0) data so pure RAM traffic is unaffected.
- Error capture:
  - err_o is set on the cycle after the miss.
  - err_addr_o latches only when err_o is currently 0, so the first error is kept.
  - If a set and err_clr_i occur in the same cycle, set wins and err_addr_o updates.
- Reset asserted mid-WAIT aborts the read: no response is issued, and all outputs return to 0 asynchronously.
- Counter width is 2 bits, with no wrap: the load value is at most 3.

Optional Feature:
- Macro: PE_PERIPH_BUS_TIMEOUT_EN.
- When defined, a 4-bit watchdog counts cycles in WAIT. Reaching 15 forces RESP with ERR_RDATA, sets err_o, and latches err_addr_o (same priority rules as a decode miss).
- When undefined, there is no watchdog and WAIT exits only via the latency counter.
- With the default latencies (max 4), the watchdog never fires; it exists for slots that will later extend WAIT.

Test Plan:
- N_SLOTS=4, SLOT_LAT=0: read 0x0100_0010 with slot0 data 0xCAFE_0001 -> slv_en_o=4'b0001 for 1 cycle, cpu_rdata_o=0xCAFE_0001 next cycle, cpu_stall_o never 1.
- SLOT_LAT=16'h00C0 (slot3 L=4): read 0x0800_0000 with slot3 data 0x1234_5678 -> cpu_stall_o=1 for 3 cycles, rdata 0x1234_5678 on the 4th cycle; cpu_en_i pulses during WAIT enable no slot.
- Back-to-back reads slot1 (L=1) then slot2 (L=1) on consecutive cycles -> each rdata appears 1 cycle after its own request, with no cross-slot mixing.
- Read 0x0300_0000 (two bits set) -> no slv_en_o, rdata=ERR_RDATA, err_o=1, err_addr_o=0x0300_0000; a later miss at 0x1000_0000 leaves err_addr_o unchanged; err_clr_i pulse -> err_o=0.
- Write 0x0000_0004 with cpu_we_i=4'hF -> no slot enabled, err_o=1; miss and err_clr_i in the same cycle -> err_o stays 1.
- rst_ni low in the 2nd WAIT cycle of a slot3 read -> all outputs 0 immediately; after release, the next read to slot0 completes normally with no stale response.

Source files
------------

// File: rtl/pe_periph_bus_if.sv
// ---------------------------------------------------------------------------
// pe_periph_bus_if
//   Core-side and slot-side signals of the processing-element peripheral
//   interconnect, bundled as one interface.
//
//   slave  modport : the interconnect's view (pe_periph_bus).
//   master modport : the environment's view (core + peripheral slots).
//
//   cpu_en_i     core memory operation enable
//   cpu_we_i     core byte write enables, 0 = read
//   cpu_addr_i   core address
//   cpu_rdata_o  read data returned to the core
//   cpu_stall_o  holds the core while a multi-cycle read is pending
//   slv_en_o     one-hot slot enable
//   slv_rdata_i  packed slot read data, slot i at [32i+31:32i]
//   err_o        sticky bus-error flag
//   err_addr_o   address of the first unserviced erroneous access
//   err_clr_i    one-cycle pulse clearing err_o
// ---------------------------------------------------------------------------
interface pe_periph_bus_if #(
  parameter int N_SLOTS = 4
) ();

  logic                    cpu_en_i;
  logic [3:0]              cpu_we_i;
  logic [31:0]             cpu_addr_i;
  logic [31:0]             cpu_rdata_o;
  logic                    cpu_stall_o;
  logic [N_SLOTS-1:0]      slv_en_o;
  logic [32*N_SLOTS-1:0]   slv_rdata_i;
  logic                    err_o;
  logic [31:0]             err_addr_o;
  logic                    err_clr_i;

  modport slave (
    input  cpu_en_i, cpu_we_i, cpu_addr_i, slv_rdata_i, err_clr_i,
    output cpu_rdata_o, cpu_stall_o, slv_en_o, err_o, err_addr_o
  );

  modport master (
    output cpu_en_i, cpu_we_i, cpu_addr_i, slv_rdata_i, err_clr_i,
    input  cpu_rdata_o, cpu_stall_o, slv_en_o, err_o, err_addr_o
  );

endinterface

// File: rtl/pe_periph_bus.sv
// ---------------------------------------------------------------------------
// pe_periph_bus
//   CPU-side peripheral interconnect. Decodes core accesses one-hot onto
//   N_SLOTS memory-mapped slots (slot i owns addr[31:24] == 1 << i), stalls
//   the core for the per-slot read latency and returns the selected slot's
//   data for exactly one cycle. Accesses that hit no slot are flagged on a
//   sticky error register that keeps the first offending address.
//
//   Ports:
//     clk_i   clock
//     rst_ni  asynchronous active-low reset
//     bus     pe_periph_bus_if.slave (core and slot signals)
//
//   Parameters:
//     N_SLOTS    number of slots, 1..8
//     SLOT_LAT   2 bits per slot, read latency = field + 1 (1..4 cycles)
//     ERR_RDATA  data returned for a read that hits no slot
//
//   Optional feature macro: PE_PERIPH_BUS_TIMEOUT_EN
//     Adds a 4-bit watchdog on the WAIT state that forces an error response
//     once it reaches 15 cycles.
// ---------------------------------------------------------------------------
module pe_periph_bus #(
  parameter int          N_SLOTS   = 4,
  parameter logic [15:0] SLOT_LAT  = 16'h0000,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pe_periph_bus_if.slave    bus
);

  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               resp_err_q, resp_err_d;
  logic               err_q;
  logic [31:0]        err_addr_q;

  // Address decode ----------------------------------------------------------
  logic [N_SLOTS-1:0] hit_vec;
  logic [IDX_W-1:0]   hit_idx;
  logic [1:0]         hit_lat_m1;
  logic               hit_any;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    hit_vec    = '0;
    hit_idx    = '0;
    hit_lat_m1 = 2'd0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (bus.cpu_addr_i[31:24] == 8'(1 << i)) begin
        hit_vec[i] = 1'b1;
        hit_idx    = IDX_W'(i);
        hit_lat_m1 = SLOT_LAT[2*i +: 2];
      end
    end
  end

  assign hit_any = |hit_vec;

  // RESP accepts a new access just like IDLE; only WAIT blocks the core.
  logic accept_ok, access, rd_acc, miss;
  assign accept_ok = (state_q != WAIT);
  assign access    = bus.cpu_en_i && accept_ok;
  assign rd_acc    = access && (bus.cpu_we_i == 4'h0);
  assign miss      = access && !hit_any;

  // Optional WAIT watchdog --------------------------------------------------
  logic        wd_fire;
  logic [31:0] err_set_addr;

`ifdef PE_PERIPH_BUS_TIMEOUT_EN
  logic [3:0]  wd_q;
  logic [31:0] req_addr_q;

  // Fires on the cycle the count reaches 15, so RESP follows immediately.
  assign wd_fire      = (state_q == WAIT) && (wd_q == 4'd14);
  assign err_set_addr = wd_fire ? req_addr_q : bus.cpu_addr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q       <= 4'd0;
      req_addr_q <= 32'h0;
    end else begin
      wd_q <= (state_q == WAIT) ? wd_q + 4'd1 : 4'd0;
      if (rd_acc) req_addr_q <= bus.cpu_addr_i;
    end
  end
`else
  assign wd_fire      = 1'b0;
  assign err_set_addr = bus.cpu_addr_i;
`endif

  // FSM next state ----------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    resp_err_d = resp_err_q;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (rd_acc) begin
          sel_d      = hit_idx;
          resp_err_d = !hit_any;
          // A miss completes like a latency-1 read (hit_lat_m1 is 0 then).
          cnt_d      = hit_lat_m1;
          state_d    = (hit_lat_m1 == 2'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = RESP;
        if (wd_fire) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
          cnt_d      = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      sel_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Error capture -----------------------------------------------------------
  // Set beats clear; the address is kept from the first error unless the
  // flag is being cleared in the same cycle a new error arrives.
  logic err_set;
  assign err_set = miss || wd_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      if (err_set)            err_q <= 1'b1;
      else if (bus.err_clr_i) err_q <= 1'b0;
      if (err_set && (!err_q || bus.err_clr_i)) err_addr_q <= err_set_addr;
    end
  end

  // Outputs -----------------------------------------------------------------
  // NOTE: the combinational outputs are gated with rst_ni so the whole port
  // reads 0 while reset is held, not just the registered ones.
  assign bus.slv_en_o    = (rst_ni && access) ? hit_vec : '0;
  assign bus.cpu_stall_o = (state_q == WAIT);
  assign bus.err_o       = err_q;
  assign bus.err_addr_o  = err_addr_q;

  always_comb begin
    bus.cpu_rdata_o = 32'h0;
    if (rst_ni) begin
      if (state_q == RESP) begin
        bus.cpu_rdata_o = resp_err_q ? ERR_RDATA
                                     : bus.slv_rdata_i[32*sel_q +: 32];
      end else begin
        // Idle default: pass the data RAM straight through.
        bus.cpu_rdata_o = bus.slv_rdata_i[31:0];
      end
    end
  end

endmodule

// File: tb/tb_pe_periph_bus.sv
// ---------------------------------------------------------------------------
// tb_pe_periph_bus
//   Self-checking bench for pe_periph_bus (N_SLOTS=4, slot3 latency 4, all
//   other slots latency 1, ERR_RDATA=DEAD_BEEF). Per-cycle vectors give the
//   inputs and expected combinational/registered outputs; expected read data
//   goes into a scoreboard queue tagged with its due cycle and is compared
//   when that cycle comes round. A hand-written sequence covers reset taken
//   in the middle of a WAIT.
// ---------------------------------------------------------------------------
module tb_pe_periph_bus;

  localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;
  localparam logic [31:0] S0_D  = 32'hCAFE_0001;
  localparam logic [31:0] S1_D  = 32'h1111_1111;
  localparam logic [31:0] S2_D  = 32'h2222_2222;
  localparam logic [31:0] S3_D  = 32'h1234_5678;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pe_periph_bus_if #(.N_SLOTS(4)) bus ();

  logic [31:0] slot_d [4];
  assign bus.slv_rdata_i = {slot_d[3], slot_d[2], slot_d[1], slot_d[0]};

  pe_periph_bus #(
    .N_SLOTS   (4),
    .SLOT_LAT  (16'h00C0),
    .ERR_RDATA (ERR_D)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic        clr;
    logic [3:0]  x_en;
    logic        x_stall;
    logic        x_err;
    logic        chk_ea;
    logic [31:0] x_ea;
    int          lat;     // 0: no read response expected
    logic [31:0] x_data;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } sb_t;

  vec_t vq[$];
  sb_t  sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(logic en, logic [3:0] we, logic [31:0] addr,
                              logic clr, logic [3:0] x_en, logic x_stall,
                              logic x_err, logic chk_ea, logic [31:0] x_ea,
                              int lat, logic [31:0] x_data);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.clr = clr; v.x_en = x_en;
    v.x_stall = x_stall; v.x_err = x_err; v.chk_ea = chk_ea; v.x_ea = x_ea;
    v.lat = lat; v.x_data = x_data;
    return v;
  endfunction

  // Drive one cycle, check at the falling edge, advance past the next rise.
  task automatic run_vec(input vec_t v);
    bus.cpu_en_i   = v.en;
    bus.cpu_we_i   = v.we;
    bus.cpu_addr_i = v.addr;
    bus.err_clr_i  = v.clr;
    @(negedge clk);
    check("slv_en", 32'(bus.slv_en_o), 32'(v.x_en));
    check("stall",  32'(bus.cpu_stall_o), 32'(v.x_stall));
    check("err",    32'(bus.err_o), 32'(v.x_err));
    if (v.chk_ea) check("err_addr", bus.err_addr_o, v.x_ea);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("rdata", bus.cpu_rdata_o, sb[0].data);
      void'(sb.pop_front());
    end else begin
      check("rdata_idle", bus.cpu_rdata_o, slot_d[0]);
    end
    if (v.lat != 0) sb.push_back('{due: cyc + v.lat, data: v.x_data});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    slot_d[0] = S0_D; slot_d[1] = S1_D; slot_d[2] = S2_D; slot_d[3] = S3_D;
    bus.cpu_en_i = 1'b0; bus.cpu_we_i = 4'h0; bus.cpu_addr_i = 32'h0;
    bus.err_clr_i = 1'b0;
    rst_n = 1'b0;

    // Reset state, including the reset-gated combinational outputs.
    bus.cpu_en_i = 1'b1; bus.cpu_addr_i = 32'h0100_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_slv_en", 32'(bus.slv_en_o), 32'h0);
    check("rst_stall",  32'(bus.cpu_stall_o), 32'h0);
    check("rst_rdata",  bus.cpu_rdata_o, 32'h0);
    check("rst_err",    32'(bus.err_o), 32'h0);
    check("rst_ea",     bus.err_addr_o, 32'h0);
    bus.cpu_en_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //               en we    addr          clr x_en    stl err ea? x_ea          lat data
    // slot0 read, latency 1
    vq.push_back(mk(1, 4'h0, 32'h0100_0010, 0, 4'b0001, 0, 0, 0, 32'h0,         1, S0_D)); // 0
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 0, 0, 32'h0,         0, 0));    // 1
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 0, 0, 32'h0,         0, 0));    // 2
    // slot3 read, latency 4; accesses during WAIT are ignored
    vq.push_back(mk(1, 4'h0, 32'h0800_0000, 0, 4'b1000, 0, 0, 0, 32'h0,         4, S3_D)); // 3
    vq.push_back(mk(1, 4'h0, 32'h0100_0000, 0, 4'b0000, 1, 0, 0, 32'h0,         0, 0));    // 4
    vq.push_back(mk(1, 4'hF, 32'h0200_0000, 0, 4'b0000, 1, 0, 0, 32'h0,         0, 0));    // 5
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 1, 0, 0, 32'h0,         0, 0));    // 6
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 0, 0, 32'h0,         0, 0));    // 7
    // back-to-back slot1, slot2
    vq.push_back(mk(1, 4'h0, 32'h0200_0000, 0, 4'b0010, 0, 0, 0, 32'h0,         1, S1_D)); // 8
    vq.push_back(mk(1, 4'h0, 32'h0400_0000, 0, 4'b0100, 0, 0, 0, 32'h0,         1, S2_D)); // 9
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 0, 0, 32'h0,         0, 0));    // 10
    // read miss (two region bits), second miss keeps first address, clear
    vq.push_back(mk(1, 4'h0, 32'h0300_0000, 0, 4'b0000, 0, 0, 0, 32'h0,         1, ERR_D));// 11
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 1, 1, 32'h0300_0000, 0, 0));    // 12
    vq.push_back(mk(1, 4'h0, 32'h1000_0000, 0, 4'b0000, 0, 1, 0, 32'h0,         1, ERR_D));// 13
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 1, 1, 32'h0300_0000, 0, 0));    // 14
    vq.push_back(mk(0, 4'h0, 32'h0,         1, 4'b0000, 0, 1, 0, 32'h0,         0, 0));    // 15
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 0, 1, 32'h0300_0000, 0, 0));    // 16
    // write miss to region 0x00; miss together with clear: set wins
    vq.push_back(mk(1, 4'hF, 32'h0000_0004, 0, 4'b0000, 0, 0, 0, 32'h0,         0, 0));    // 17
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 1, 1, 32'h0000_0004, 0, 0));    // 18
    vq.push_back(mk(1, 4'hF, 32'h0000_0008, 1, 4'b0000, 0, 1, 0, 32'h0,         0, 0));    // 19
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 1, 1, 32'h0000_0008, 0, 0));    // 20
    vq.push_back(mk(0, 4'h0, 32'h0,         1, 4'b0000, 0, 1, 0, 32'h0,         0, 0));    // 21
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 0, 0, 32'h0,         0, 0));    // 22
    // posted write hit: one-cycle enable, no stall, no error
    vq.push_back(mk(1, 4'h3, 32'h0400_0000, 0, 4'b0100, 0, 0, 0, 32'h0,         0, 0));    // 23
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 0, 0, 1, 32'h0000_0008, 0, 0));    // 24
    // set up for reset during WAIT: pending error, then a slot3 read
    vq.push_back(mk(1, 4'h1, 32'h0000_00F0, 0, 4'b0000, 0, 0, 0, 32'h0,         0, 0));    // 25
    vq.push_back(mk(1, 4'h0, 32'h0800_0000, 0, 4'b1000, 0, 1, 1, 32'h0000_00F0, 0, 0));    // 26
    vq.push_back(mk(0, 4'h0, 32'h0,         0, 4'b0000, 1, 1, 0, 32'h0,         0, 0));    // 27

    foreach (vq[i]) run_vec(vq[i]);

    // Second WAIT cycle of the slot3 read: assert reset mid-cycle.
    bus.cpu_en_i = 1'b1; bus.cpu_we_i = 4'h0; bus.cpu_addr_i = 32'h0100_0000;
    #2;
    check("wait2_stall", 32'(bus.cpu_stall_o), 32'h1);
    check("sb_empty_pre_rst", 32'(sb.size()), 32'h0);
    rst_n = 1'b0;
    #1;
    check("arst_stall",  32'(bus.cpu_stall_o), 32'h0);
    check("arst_slv_en", 32'(bus.slv_en_o), 32'h0);
    check("arst_rdata",  bus.cpu_rdata_o, 32'h0);
    check("arst_err",    32'(bus.err_o), 32'h0);
    check("arst_ea",     bus.err_addr_o, 32'h0);
    bus.cpu_en_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;

    // After release: slot0 read completes, no stale slot3 response follows.
    slot_d[0] = 32'hABCD_0000;
    vq.delete();
    vq.push_back(mk(1, 4'h0, 32'h0100_0000, 0, 4'b0001, 0, 0, 0, 32'h0, 1, 32'hABCD_0000));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 4'h0, 32'h0, 0, 4'b0000, 0, 0, 1, 32'h0, 0, 0));
    foreach (vq[i]) run_vec(vq[i]);

    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls on the clock.
  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, want finish before 100000");
    $fatal(1);
  end

endmodule
